prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a counted byte stream of 13-bit instructions and writes them to program memory.
// It holds the CPU in reset until the load is done. Defining PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader #(
  parameter int MAX_INST = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_wr,
  output logic [7:0]  mem_addr,
  output logic [12:0] mem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] MAX_INST_C = 8'(MAX_INST);

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_LAST = ST_CSUM;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  logic [7:0] sum_r;
`else
  localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        wr_s;
  logic [7:0]  count_r;
  logic [7:0]  index_r;
  logic [4:0]  hi_r;
  logic        mem_wr_r;
  logic [7:0]  mem_addr_r;
  logic [12:0] mem_data_r;
  logic        cpu_reset_r;
  logic        done_r;
  logic        error_r;

  assign in_ready  = (state_r != ST_DONE) && (state_r != ST_ERR);
  assign accept_s  = in_valid && in_ready;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_data  = mem_data_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign error     = error_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_COUNT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and write-strobe generation for the accepted byte.
  always_comb begin
    next_state_s = state_r;
    wr_s         = 1'b0;
    case (state_r)
      ST_COUNT: begin
        if (!accept_s) begin
          next_state_s = ST_COUNT;
        end else if ((in_data == 8'd0) || (in_data > MAX_INST_C)) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_HI;
        end
      end
      ST_HI: begin
        if (!accept_s) begin
          next_state_s = ST_HI;
        end else if (in_data[7:5] != 3'd0) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_LO;
        end
      end
      ST_LO: begin
        if (!accept_s) begin
          next_state_s = ST_LO;
        end else if (index_r == (count_r - 8'd1)) begin
          wr_s         = 1'b1;
          next_state_s = ST_AFTER_LAST;
        end else begin
          wr_s         = 1'b1;
          next_state_s = ST_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!accept_s) begin
          next_state_s = ST_CSUM;
        end else if (csum_add(sum_r, in_data) == 8'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ERR;
        end
      end
`endif
      ST_DONE: next_state_s = ST_DONE;
      ST_ERR:  next_state_s = ST_ERR;
      default: next_state_s = ST_ERR;
    endcase
  end

  // Datapath and registered outputs; done/cpu_reset are staggered so memory settles before the CPU runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= 8'd0;
      index_r     <= 8'd0;
      hi_r        <= 5'd0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= 8'd0;
      mem_data_r  <= 13'd0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
    end else begin
      mem_wr_r <= wr_s;
      if (accept_s && (state_r == ST_COUNT)) begin
        count_r <= in_data;
        index_r <= 8'd0;
      end
      if (accept_s && (state_r == ST_HI)) begin
        hi_r <= in_data[4:0];
      end
      if (wr_s) begin
        mem_addr_r <= index_r;
        mem_data_r <= {hi_r, in_data};
        index_r    <= index_r + 8'd1;
      end
      done_r      <= (next_state_s == ST_DONE);
      error_r     <= (next_state_s == ST_ERR);
      cpu_reset_r <= (state_r != ST_DONE);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running mod-256 sum over every accepted byte, count included.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= 8'd0;
    end else if (accept_s) begin
      sum_r <= csum_add(sum_r, in_data);
    end else begin
      sum_r <= sum_r;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (MAX_INST = 14).
// With PROG_LOADER_CHECKSUM_EN defined, images get a computed checksum byte appended.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [12:0] mem_data;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  img_q[$];
  logic [20:0] wlog_q[$];

  prog_loader #(.MAX_INST(14)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every write pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) wlog_q.push_back({mem_addr, mem_data});
  end

  // Called at a negedge; presents one byte across exactly one rising edge.
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wlog_q.delete();
  endtask

  // Sends img_q with 'gap' idle cycles between bytes (plus checksum when enabled).
  task automatic send_image(input int gap);
    logic [7:0] s;
    s = 8'd0;
    foreach (img_q[i]) s = s + img_q[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    img_q.push_back(8'd0 - s);
`endif
    foreach (img_q[i]) begin
      send_byte(img_q[i]);
      if (i != img_q.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 8'h00;
    do_reset();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    n_cmp++; if ({done, error} !== 2'b00) begin n_bad++; $display("FAIL reset_done_err got %b want 00", {done, error}); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
    n_cmp++; if ({mem_addr, mem_data} !== 21'd0) begin n_bad++; $display("FAIL reset_addr_data got %h want 0", {mem_addr, mem_data}); end
  endtask

  // Two-instruction image, optionally with stall cycles between bytes.
  task automatic test_load(input string nm, input int gap);
    do_reset();
    img_q = '{8'h02, 8'h00, 8'h00, 8'h18, 8'h01};
    send_image(gap);
    n_cmp++; if ({done, error, cpu_reset} !== 3'b101) begin n_bad++; $display("FAIL %s_done_edge got %b want 101", nm, {done, error, cpu_reset}); end
    @(negedge clk);
    n_cmp++; if ({done, cpu_reset, in_ready} !== 3'b100) begin n_bad++; $display("FAIL %s_cpu_run got %b want 100", nm, {done, cpu_reset, in_ready}); end
    repeat (2) @(negedge clk);
    n_cmp++; if (wlog_q.size() !== 2) begin n_bad++; $display("FAIL %s_nwrites got %0d want 2", nm, wlog_q.size()); end
    else begin
      n_cmp++; if (wlog_q[0] !== {8'd0, 13'h0000}) begin n_bad++; $display("FAIL %s_write0 got %h want %h", nm, wlog_q[0], {8'd0, 13'h0000}); end
      n_cmp++; if (wlog_q[1] !== {8'd1, 13'h1801}) begin n_bad++; $display("FAIL %s_write1 got %h want %h", nm, wlog_q[1], {8'd1, 13'h1801}); end
    end
  endtask

  task automatic test_bad_count(input logic [7:0] cnt);
    do_reset();
    send_byte(cnt);
    n_cmp++; if ({error, done, in_ready, cpu_reset} !== 4'b1001) begin n_bad++; $display("FAIL bad_count_%h got %b want 1001", cnt, {error, done, in_ready, cpu_reset}); end
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    n_cmp++; if (wlog_q.size() !== 0 || error !== 1'b1) begin n_bad++; $display("FAIL bad_count_%h_sticky got writes=%0d err=%b want 0 1", cnt, wlog_q.size(), error); end
  endtask

  task automatic test_max_count();
    do_reset();
    send_byte(8'h0E);
    n_cmp++; if ({error, in_ready} !== 2'b01) begin n_bad++; $display("FAIL max_count got %b want 01", {error, in_ready}); end
  endtask

  task automatic test_bad_hi();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h20);
    n_cmp++; if ({error, done, cpu_reset} !== 3'b101) begin n_bad++; $display("FAIL bad_hi got %b want 101", {error, done, cpu_reset}); end
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    n_cmp++; if (wlog_q.size() !== 0 || cpu_reset !== 1'b1) begin n_bad++; $display("FAIL bad_hi_hold got writes=%0d cpu_reset=%b want 0 1", wlog_q.size(), cpu_reset); end
  endtask

  // Reset mid-load abandons it; the next image lands at address 0.
  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h18);
    do_reset();
    img_q = '{8'h01, 8'h05, 8'h0A};
    send_image(0);
    repeat (3) @(negedge clk);
    n_cmp++; if ({done, error, cpu_reset} !== 3'b100) begin n_bad++; $display("FAIL reset_mid_state got %b want 100", {done, error, cpu_reset}); end
    n_cmp++; if (wlog_q.size() !== 1) begin n_bad++; $display("FAIL reset_mid_nwrites got %0d want 1", wlog_q.size()); end
    else begin
      n_cmp++; if (wlog_q[0] !== {8'd0, 13'h050A}) begin n_bad++; $display("FAIL reset_mid_write got %h want %h", wlog_q[0], {8'd0, 13'h050A}); end
    end
  endtask

  // Reset coinciding with the LO byte suppresses its write; next byte is a count.
  task automatic test_reset_pending();
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    in_data = 8'h33; in_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    n_cmp++; if ({mem_wr, in_ready, done, error} !== 4'b0100) begin n_bad++; $display("FAIL reset_pending got %b want 0100", {mem_wr, in_ready, done, error}); end
    send_byte(8'h00);
    @(negedge clk);
    n_cmp++; if (error !== 1'b1 || wlog_q.size() !== 0) begin n_bad++; $display("FAIL reset_pending_count got err=%b writes=%0d want 1 0", error, wlog_q.size()); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] cs, input logic want_ok);
    do_reset();
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL csum_%h_early_done got %b want 0", cs, done); end
    send_byte(cs);
    repeat (2) @(negedge clk);
    n_cmp++; if ({done, error} !== {want_ok, ~want_ok}) begin n_bad++; $display("FAIL csum_%h_result got %b want %b", cs, {done, error}, {want_ok, ~want_ok}); end
    n_cmp++; if (cpu_reset !== ~want_ok) begin n_bad++; $display("FAIL csum_%h_cpu_reset got %b want %b", cs, cpu_reset, ~want_ok); end
    n_cmp++; if (wlog_q.size() !== 1 || wlog_q[0] !== {8'd0, 13'h0400}) begin n_bad++; $display("FAIL csum_%h_write got n=%0d", cs, wlog_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PROG_LOADER_CHECKSUM_EN
    test_load("basic", 0);
    test_load("stall", 3);
`endif
    test_bad_count(8'h00);
    test_bad_count(8'h0F);
    test_max_count();
    test_bad_hi();
    test_reset_pending();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum(8'hFB, 1'b1);
    test_checksum(8'hFC, 1'b0);
`else
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
